// File: rtl/filter_pkg.sv
// Shared definitions for the 3x3 window filter frame path.
//   DEF_IMG_WIDTH / DEF_IMG_HEIGHT : default frame geometry
//   DEF_BORDER_VAL                 : default value written for border pixels
//   seq_state_t                    : frame sequencer state type
package filter_pkg;

    localparam int unsigned DEF_IMG_WIDTH  = 225;
    localparam int unsigned DEF_IMG_HEIGHT = 225;
    localparam logic [7:0]  DEF_BORDER_VAL = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/filter_out_fifo.sv
// Synchronous 8-bit output FIFO with an occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_wdata (dropped only if full with no pop)
//   i_pop      : remove head (ignored when empty; no fall-through)
//   o_rdata    : head entry
//   o_empty    : FIFO holds no entries
//   o_count    : number of entries held
module filter_out_fifo #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [7:0]       i_wdata,
    input  logic             i_pop,
    output logic [7:0]       o_rdata,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // A pop on empty is ignored, so an empty FIFO never forwards its input.
    // A push on full is accepted only when a pop frees the slot this cycle.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/filter_frame_sequencer.sv
// Sequences one frame from the source buffer through the 3x3 window filter
// into the destination buffer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start / busy / done : frame control (start pulse, in-progress, end pulse)
//   src_rd_en/src_addr  : source read request (data returns 1 cycle later)
//   src_rdata           : source read data
//   f_de / f_data       : filter input beat
//   f_o_de / f_o_data   : filter output beat
//   dst_wr_en/dst_addr/dst_wdata/dst_ready : destination write handshake
module filter_frame_sequencer
    import filter_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int unsigned FILTER_LAT = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  BORDER_VAL = DEF_BORDER_VAL,
    parameter int unsigned ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [7:0]        src_rdata,
    output logic              f_de,
    output logic [7:0]        f_data,
    input  logic              f_o_de,
    input  logic [7:0]        f_o_data,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [7:0]        dst_wdata,
    input  logic              dst_ready
);

    // The FIFO must cover the filter pipeline plus the read stage and one
    // beat of slack, otherwise issue would stall on every beat.
    localparam int unsigned DEPTH  = (FIFO_DEPTH < FILTER_LAT + 2) ? FILTER_LAT + 2 : FIFO_DEPTH;
    localparam int unsigned NPIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned NPAD   = 2 * IMG_WIDTH;
    localparam int unsigned NOUT   = NPIX + NPAD;
    localparam int unsigned K_W    = $clog2(NOUT + 1);
    localparam int unsigned PAD_W  = $clog2(NPAD + 1);
    localparam int unsigned COL_W  = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W  = $clog2(IMG_HEIGHT);
    localparam int unsigned FCNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W  = $clog2(2 * DEPTH + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [PAD_W-1:0]  PAD_LAST  = PAD_W'(NPAD - 1);
    localparam logic [K_W-1:0]    K_FIRST   = K_W'(IMG_WIDTH + 1);
    localparam logic [K_W-1:0]    K_END     = K_W'(IMG_WIDTH + 1 + NPIX);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_src_addr;
    logic [ADDR_W-1:0] r_dst_addr;
    logic [PAD_W-1:0]  r_pad_cnt;
    logic [K_W-1:0]    r_out_k;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [OCC_W-1:0]  r_inflight;
    logic              r_beat_vld;
    logic              r_beat_pad;

    logic              w_issue;
    logic              w_room;
    logic              w_start_acc;
    logic              w_in_frame;
    logic              w_ret;
    logic              w_keep;
    logic              w_border;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_empty;
    logic [FCNT_W-1:0] w_fifo_cnt;
    logic [7:0]        w_fifo_rdata;
    logic [7:0]        w_push_data;

    assign w_in_frame  = (r_state == ST_STREAM) || (r_state == ST_FLUSH) || (r_state == ST_DRAIN);
    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_room      = (r_inflight + OCC_W'(w_fifo_cnt)) < OCC_W'(DEPTH);

    // Returns are only meaningful for beats this frame issued.
    assign w_ret    = f_o_de && w_in_frame && (r_inflight != '0);
    assign w_keep   = w_ret && (r_out_k >= K_FIRST) && (r_out_k < K_END);
    assign w_border = (r_row == '0) || (r_row == ROW_LAST) || (r_col == '0) || (r_col == COL_LAST);
    assign w_push      = w_keep;
    assign w_push_data = w_border ? BORDER_VAL : f_o_data;
    assign w_pop       = !w_fifo_empty && dst_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DRAIN also waits for the trailing pad outputs to retire, so the next
    // frame's output beat index starts from a clean pipeline.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                w_issue = w_room;
                if (w_issue && (r_src_addr == LAST_ADDR)) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_issue = w_room;
                if (w_issue && (r_pad_cnt == PAD_LAST)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((r_inflight == '0) && w_fifo_empty) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_addr <= '0;
            r_dst_addr <= '0;
            r_pad_cnt  <= '0;
            r_out_k    <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_inflight <= '0;
            r_beat_vld <= 1'b0;
            r_beat_pad <= 1'b0;
        end else begin
            r_beat_vld <= w_issue;
            r_beat_pad <= w_issue && (r_state == ST_FLUSH);
            if (w_start_acc) begin
                r_src_addr <= '0;
                r_dst_addr <= '0;
                r_pad_cnt  <= '0;
                r_out_k    <= '0;
                r_col      <= '0;
                r_row      <= '0;
                r_inflight <= '0;
            end else begin
                if (w_issue && (r_state == ST_STREAM)) begin
                    r_src_addr <= (r_src_addr == LAST_ADDR) ? '0 : r_src_addr + 1'b1;
                end
                if (w_issue && (r_state == ST_FLUSH)) begin
                    r_pad_cnt <= (r_pad_cnt == PAD_LAST) ? '0 : r_pad_cnt + 1'b1;
                end
                case ({w_issue, w_ret})
                    2'b10:   r_inflight <= r_inflight + 1'b1;
                    2'b01:   r_inflight <= r_inflight - 1'b1;
                    default: r_inflight <= r_inflight;
                endcase
                if (w_ret) begin
                    r_out_k <= r_out_k + 1'b1;
                end
                if (w_keep) begin
                    if (r_col == COL_LAST) begin
                        r_col <= '0;
                        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                if (w_pop) begin
                    r_dst_addr <= (r_dst_addr == LAST_ADDR) ? '0 : r_dst_addr + 1'b1;
                end
            end
        end
    end

    filter_out_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_cnt)
    );

    assign busy      = w_in_frame;
    assign done      = (r_state == ST_DONE);
    assign src_rd_en = w_issue && (r_state == ST_STREAM);
    assign src_addr  = r_src_addr;
    assign f_de      = r_beat_vld;
    assign f_data    = (r_beat_vld && !r_beat_pad) ? src_rdata : 8'h00;
    assign dst_wr_en = !w_fifo_empty;
    assign dst_addr  = r_dst_addr;
    assign dst_wdata = w_fifo_empty ? 8'h00 : w_fifo_rdata;

endmodule
